// File: rtl/pending_encoder_pkg.sv
// Shared definitions for the pending encoder: default index width and vector-width helper.
package pending_encoder_pkg;
  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEF_VEC_W     = 1 << DEF_ADDR_SIZE;

  function automatic int vec_width(input int addr_size);
    return 1 << addr_size;
  endfunction
endpackage

// File: rtl/pending_encoder_prio_enc.sv
// Combinational priority encoder: first set bit of i_vec searching upward from i_start, with wrap.
module prio_enc
  import pending_encoder_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic [(1<<ADDR_SIZE)-1:0] i_vec,
  input  logic [ADDR_SIZE-1:0]      i_start,
  output logic                      o_found,
  output logic [ADDR_SIZE-1:0]      o_idx
);
  localparam int W = vec_width(ADDR_SIZE);

  logic [ADDR_SIZE-1:0] w_j;

  // Walk from the far end back toward i_start so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_j     = '0;
    for (int k = W - 1; k >= 0; k--) begin
      w_j = i_start + ADDR_SIZE'(k);
      if (i_vec[w_j]) begin
        o_found = 1'b1;
        o_idx   = w_j;
      end
    end
  end
endmodule

// File: rtl/pending_encoder.sv
// Captures request rising edges into a sticky pending vector and emits their indices over valid/ready.
// Define PENDING_ENCODER_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [(1<<ADDR_SIZE)-1:0] req,
  input  logic                      flush,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ADDR_SIZE-1:0]      out_addr,
  output logic [(1<<ADDR_SIZE)-1:0] pending,
  output logic                      any_pend
);
  localparam int W = vec_width(ADDR_SIZE);

  logic [W-1:0]         r_req_q;
  logic [W-1:0]         r_pending;
  logic                 r_out_valid;
  logic [ADDR_SIZE-1:0] r_out_addr;
  logic [ADDR_SIZE-1:0] r_rr_ptr;

  logic [W-1:0]         w_rise;
  logic [W-1:0]         w_clr;
  logic [ADDR_SIZE-1:0] w_start;
  logic                 w_found;
  logic [ADDR_SIZE-1:0] w_idx;
  logic                 w_stage_free;
  logic                 w_load;

  assign w_rise = req & ~r_req_q;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  prio_enc #(.ADDR_SIZE(ADDR_SIZE)) u_prio_enc (
    .i_vec   (r_pending),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // Only already-registered pending bits are eligible, giving the two-edge request latency.
  assign w_stage_free = !r_out_valid || out_ready;
  assign w_load       = w_stage_free && w_found;
  assign w_clr        = w_load ? ({{(W-1){1'b0}}, 1'b1} << w_idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_req_q     <= '0;
      r_pending   <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_req_q <= req;
      if (flush) begin
        r_pending   <= '0;
        r_out_valid <= 1'b0;
        r_rr_ptr    <= '0;
      end else begin
        // A rise landing on the bit being loaded keeps it pending so the event is not lost.
        r_pending <= (r_pending & ~w_clr) | w_rise;
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_addr  <= w_idx;
          r_rr_ptr    <= w_idx + 1'b1;
        end else if (w_stage_free) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_addr  = r_out_addr;
  assign pending   = r_pending;
  assign any_pend  = |r_pending;
endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: scoreboard of expected indices plus per-scenario checks.
module tb_pending_encoder;
  localparam int A = 4;
  localparam int W = 1 << A;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] req;
  logic         flush;
  logic         out_ready;
  logic         out_valid;
  logic [A-1:0] out_addr;
  logic [W-1:0] pending;
  logic         any_pend;

  int errors = 0;
  int checks = 0;
  logic [A-1:0] exp_q[$];

  pending_encoder #(.ADDR_SIZE(A)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .pending   (pending),
    .any_pend  (any_pend)
  );

  always #5 clk = ~clk;

  // One cycle: score any accept at the falling edge, then advance past the rising edge.
  task automatic step();
    logic [A-1:0] exp_addr;
    @(negedge clk);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got addr %0d, expected no delivery", out_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        if (out_addr !== exp_addr) begin
          errors++;
          $display("FAIL sb_order: got addr %0d, expected %0d", out_addr, exp_addr);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++;
    if ({out_valid, out_addr, pending, any_pend} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b addr=%0d pend=%h any=%b, expected all 0",
               out_valid, out_addr, pending, any_pend);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req[5] = 1'b1; exp_q.push_back(4'd5);
    step();
    req = '0;
    checks++;
    if (out_valid !== 1'b0 || pending !== 16'h0020) begin
      errors++;
      $display("FAIL single_pend: valid=%b pend=%h, expected 0 / 0020", out_valid, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd5 || pending !== '0) begin
      errors++;
      $display("FAIL single_out: valid=%b addr=%0d pend=%h, expected 1 / 5 / 0000",
               out_valid, out_addr, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || any_pend !== 1'b0) begin
      errors++;
      $display("FAIL single_done: valid=%b any=%b, expected 0 / 0", out_valid, any_pend);
    end
  endtask

  task automatic test_fixed_order();
    req[3] = 1'b1; req[9] = 1'b1;
    exp_q.push_back(4'd3); exp_q.push_back(4'd9);
    step();
    req = '0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd3) begin
      errors++;
      $display("FAIL order_first: valid=%b addr=%0d, expected 1 / 3", out_valid, out_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd9) begin
      errors++;
      $display("FAIL order_second: valid=%b addr=%0d, expected 1 / 9", out_valid, out_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_idle: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    req[9] = 1'b1; exp_q.push_back(4'd9);
    step();
    req = '0;
    step();
    req[1] = 1'b1; exp_q.push_back(4'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      req = '0;
      checks++;
      if (out_valid !== 1'b1 || out_addr !== 4'd9) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b addr=%0d, expected 1 / 9", i, out_valid, out_addr);
      end
    end
    checks++;
    if (pending !== 16'h0002) begin
      errors++;
      $display("FAIL stall_pend: pend=%h, expected 0002", pending);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd1 || pending !== '0) begin
      errors++;
      $display("FAIL stall_next: valid=%b addr=%0d pend=%h, expected 1 / 1 / 0000",
               out_valid, out_addr, pending);
    end
    step();
  endtask

  task automatic test_collision();
    out_ready = 1'b0;
    req[9] = 1'b1; exp_q.push_back(4'd9);
    step();
    req[9] = 1'b0; req[4] = 1'b1; exp_q.push_back(4'd4);
    step();
    req[4] = 1'b0;
    step();
    // Accept 9 and load 4 on the same edge that 4 rises again.
    out_ready = 1'b1;
    req[4] = 1'b1; exp_q.push_back(4'd4);
    step();
    req = '0;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd4 || pending !== 16'h0010) begin
      errors++;
      $display("FAIL collide_set_wins: valid=%b addr=%0d pend=%h, expected 1 / 4 / 0010",
               out_valid, out_addr, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd4 || pending !== '0) begin
      errors++;
      $display("FAIL collide_redeliver: valid=%b addr=%0d pend=%h, expected 1 / 4 / 0000",
               out_valid, out_addr, pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle: valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_flush_reset();
    out_ready = 1'b0;
    req = 16'h0F0F;
    step();
    req = '0;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 4'd0 || pending !== 16'h0F0E) begin
      errors++;
      $display("FAIL flush_setup: valid=%b addr=%0d pend=%h, expected 1 / 0 / 0F0E",
               out_valid, out_addr, pending);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || pending !== '0 || any_pend !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear: valid=%b pend=%h any=%b, expected 0 / 0000 / 0",
               out_valid, pending, any_pend);
    end
    req = 16'h0F0F;
    step();
    req = '0;
    step();
    reset_n = 1'b0;
    step();
    checks++;
    if ({out_valid, out_addr, pending, any_pend} !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b addr=%0d pend=%h any=%b, expected all 0",
               out_valid, out_addr, pending, any_pend);
    end
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_bursts();
    for (int b = 0; b < 3; b++) begin
      req[2] = 1'b1; req[7] = 1'b1;
      exp_q.push_back(4'd2); exp_q.push_back(4'd7);
      step();
      req = '0;
      step(); step(); step();
    end
    step();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sb_drain: %0d deliveries missing, valid=%b, expected 0 / 0",
               exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_order();
    test_stall();
    test_collision();
    test_flush_reset();
    test_bursts();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
